ifft8_seq: RTL and testbench
============================

Name: ifft8_seq

Overview:
- Sequential 8-point radix-2 DIT inverse FFT; the return path for the parallel 8-point forward FFT.
- Accepts 8 complex frequency bins serially, in natural order X0..X7.
- Computes the inverse with one shared complex butterfly, time-multiplexed over 12 butterfly cycles.
- Streams 8 time-domain samples x0..x7 out in natural order.
- Data format is the same as the forward FFT: 24-bit signed real/imag, twiddles Q2.13 (0x2000 = 1.0).

Parameters:
- DW, 24, data width of each real/imag component.
- TW, 16, twiddle width (Q2.13).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input bin present.
- in_ready  out  1  block can accept a bin.
- in_real  in  DW  bin real part, signed.
- in_imag  in  DW  bin imag part, signed.
- out_valid  out  1  output sample present.
- out_ready  in  1  downstream accepts sample.
- out_real  out  DW  sample real part, signed.
- out_imag  out  DW  sample imag part, signed.
- out_last  out  1  high with sample index 7.
- busy  out  1  high in CALC or UNLOAD.

Behaviour:
- Reset (rst=1 at posedge):
  - state=LOAD; load/calc/unload counters=0.
  - in_ready=1; out_valid=0; out_last=0; busy=0.
  - out_real and out_imag = 0.
  - Storage contents are don't-care.
- Transfer rule: a handshake completes on a posedge where valid&&ready.
  - Source must hold data stable while valid&&!ready.
- Storage: 8-entry complex register file.
- LOAD (in_ready=1):
  - Bin n is written to storage address bitrev3(n), e.g. n=1 goes to address 4.
  - After the 8th accepted bin: go to CALC; in_ready=0 from the next cycle.
- CALC (12 cycles, in_ready=0, busy=1): one butterfly per cycle, counter c=0..11.
  - Stage m = c/4; unit k = c%4; j = k mod 2^m.
  - p = ((k>>m)<<(m+1)) + j; q = p + 2^m.
  - Twiddle index t = j<<(2-m), using the conjugate table W^-t:
    - t=0: (0x2000, 0x0000)
    - t=1: (0x16A0, 0x16A0)
    - t=2: (0x0000, 0x2000)
    - t=3: (0xE95F, 0x16A0)
  - Product: tr/ti = (xq*W) with full-precision multiply, then arithmetic shift right 13.
    - tr and ti are kept at DW+1 bits; -1 x -2^23 must not wrap.
  - yp = (xp + t) >>> 1 and yq = (xp - t) >>> 1.
    - Sums use DW+2 bits; the shift truncates toward -inf.
    - Result saturates to the DW signed range.
  - Read is combinational from storage; yp/yq are written in place to p/q on the same posedge.
  - Pairs are disjoint within a stage, so there is no hazard across stage boundaries.
  - Total scaling is 1/8, which is exact IFFT normalisation.
  - After c=11: go to UNLOAD.
- UNLOAD (busy=1):
  - out_valid=1, presenting address u = 0..7 (natural order).
  - out_last=1 when u=7.
  - u advances only on a handshake; outputs are held stable while out_ready=0.
  - After the u=7 handshake, on the next cycle: out_valid=0, in_ready=1, busy=0, state=LOAD.
- Latency: first out_valid is asserted 12 cycles after the posedge that accepts bin 7.
  - Minimum frame period is 8+12+8 = 28 cycles.
- Input during CALC/UNLOAD: in_valid is ignored because in_ready=0; nothing is dropped silently.
- Reset mid-frame (any state): abort the frame. The partial frame is never output.
  - The next frame loads from bin 0.

Test Plan:
- Impulse in bin 0: X0=(8,0), other bins 0 -> all eight outputs (1,0); out_last only on the 8th sample; first out_valid 12 cycles after the last input handshake.
- Flat spectrum: all bins (8,0) -> x0=(8,0), x1..x7=(0,0).
- Single tone: X1=(65536,0), rest 0 -> expected values, each within ±1 LSB:
  - x0=(8192,0), x1=(5792,5792), x2=(0,8192), x3=(-5792,5792)
  - x4=(-8192,0), x5=(-5792,-5792), x6=(0,-8192), x7=(5792,-5792)
- Backpressure: out_ready=0 for 5 cycles while x3 is presented -> out_valid, out_real and out_imag stay stable; in_ready stays 0; the sequence resumes with no loss or duplication.
- Saturation: all bins (-8388608, -8388608) -> no wrap; x0=(-8388608,-8388608) and all other outputs within ±1 LSB of 0.
- Reset during CALC (c=5), then a new flat-spectrum frame -> out_valid stays 0 until the new frame completes, in_ready=1 on the cycle after reset, and the output matches the flat-spectrum case.

Source files
------------

// File: rtl/ifft8_seq_if.sv
// Streaming port bundle for ifft8_seq: frequency bins in, time samples out,
// plus the busy status flag. The master side is the producer/consumer around the block.
interface ifft8_seq_if #(
  parameter int DW = 24
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_real;
  logic signed [DW-1:0] in_imag;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_real;
  logic signed [DW-1:0] out_imag;
  logic                 out_last;
  logic                 busy;

  modport master (
    output in_valid, in_real, in_imag, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_last, busy
  );

  modport slave (
    input  in_valid, in_real, in_imag, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_last, busy
  );
endinterface

// File: rtl/ifft8_seq.sv
// Sequential 8-point radix-2 DIT inverse FFT: serial load in bit-reversed order,
// 12 in-place butterflies through one shared complex unit, serial natural-order unload.
module ifft8_seq #(
  parameter int DW = 24,
  parameter int TW = 16
) (
  input  logic       clk,
  input  logic       rst,
  ifft8_seq_if.slave bus
);
  localparam int FRAC = 13;
  localparam int PW   = DW + TW;

  // Conjugate twiddles W^-t in Q2.13.
  localparam logic signed [TW-1:0] W_ONE   = TW'(16'sh2000);
  localparam logic signed [TW-1:0] W_HALF  = TW'(16'sh16A0);
  localparam logic signed [TW-1:0] W_NHALF = TW'(16'shE95F);

  typedef enum logic [1:0] {LOAD, CALC, UNLOAD} state_t;

  state_t               state, state_nxt;
  logic [2:0]           load_cnt, unload_cnt;
  logic [3:0]           calc_cnt;
  logic [2:0]           load_addr;
  logic                 in_fire, out_fire;

  logic signed [DW-1:0] mem_re [8];
  logic signed [DW-1:0] mem_im [8];

  logic [1:0]           stage, unit, tw_idx;
  logic [2:0]           addr_p, addr_q;
  logic signed [TW-1:0] w_re, w_im;
  logic signed [DW-1:0] xp_re, xp_im, xq_re, xq_im;
  logic signed [PW:0]   prod_re, prod_im;
  logic signed [DW:0]   t_re, t_im;
  logic signed [DW+1:0] sum_p_re, sum_p_im, sum_q_re, sum_q_im;
  logic signed [DW-1:0] yp_re, yp_im, yq_re, yq_im;

  function automatic logic signed [PW-1:0] mul(input logic signed [DW-1:0] a,
                                               input logic signed [TW-1:0] b);
    logic signed [PW-1:0] ae, be;
    ae = PW'(a);
    be = PW'(b);
    return ae * be;
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [DW:0] v);
    if (v[DW] != v[DW-1])
      return v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return v[DW-1:0];
  endfunction

  // Handshakes derive from state directly so they never loop through the port drivers.
  assign in_fire   = bus.in_valid  && (state == LOAD);
  assign out_fire  = bus.out_ready && (state == UNLOAD);
  assign load_addr = {load_cnt[0], load_cnt[1], load_cnt[2]};

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.busy      = 1'b0;
    bus.out_real  = '0;
    bus.out_imag  = '0;
    unique case (state)
      LOAD: begin
        bus.in_ready = 1'b1;
        if (in_fire && load_cnt == 3'd7) state_nxt = CALC;
      end
      CALC: begin
        bus.busy = 1'b1;
        if (calc_cnt == 4'd11) state_nxt = UNLOAD;
      end
      UNLOAD: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_last  = (unload_cnt == 3'd7);
        bus.out_real  = mem_re[unload_cnt];
        bus.out_imag  = mem_im[unload_cnt];
        if (out_fire && unload_cnt == 3'd7) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Butterfly addressing: p = ((k>>m)<<(m+1)) + (k mod 2^m), q = p + 2^m, t = j<<(2-m).
  always_comb begin
    stage  = calc_cnt[3:2];
    unit   = calc_cnt[1:0];
    addr_p = {unit, 1'b0};
    addr_q = {unit, 1'b1};
    tw_idx = 2'd0;
    case (stage)
      2'd0: begin
        addr_p = {unit, 1'b0};
        addr_q = {unit, 1'b1};
        tw_idx = 2'd0;
      end
      2'd1: begin
        addr_p = {unit[1], 1'b0, unit[0]};
        addr_q = {unit[1], 1'b1, unit[0]};
        tw_idx = {unit[0], 1'b0};
      end
      default: begin
        addr_p = {1'b0, unit};
        addr_q = {1'b1, unit};
        tw_idx = unit;
      end
    endcase

    w_re = W_ONE;
    w_im = '0;
    case (tw_idx)
      2'd0: begin w_re = W_ONE;   w_im = '0;     end
      2'd1: begin w_re = W_HALF;  w_im = W_HALF; end
      2'd2: begin w_re = '0;      w_im = W_ONE;  end
      default: begin w_re = W_NHALF; w_im = W_HALF; end
    endcase

    xp_re = mem_re[addr_p];
    xp_im = mem_im[addr_p];
    xq_re = mem_re[addr_q];
    xq_im = mem_im[addr_q];

    prod_re = (PW+1)'(mul(xq_re, w_re)) - (PW+1)'(mul(xq_im, w_im));
    prod_im = (PW+1)'(mul(xq_re, w_im)) + (PW+1)'(mul(xq_im, w_re));
    // Arithmetic shift by FRAC, kept one bit wider than the data so -1 * -2^23 survives.
    t_re = prod_re[DW+FRAC:FRAC];
    t_im = prod_im[DW+FRAC:FRAC];

    sum_p_re = (DW+2)'(xp_re) + (DW+2)'(t_re);
    sum_p_im = (DW+2)'(xp_im) + (DW+2)'(t_im);
    sum_q_re = (DW+2)'(xp_re) - (DW+2)'(t_re);
    sum_q_im = (DW+2)'(xp_im) - (DW+2)'(t_im);

    // Per-stage halving gives the exact 1/8 IFFT normalisation; the drop of bit 0 floors.
    yp_re = sat(sum_p_re[DW+1:1]);
    yp_im = sat(sum_p_im[DW+1:1]);
    yq_re = sat(sum_q_re[DW+1:1]);
    yq_im = sat(sum_q_im[DW+1:1]);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      load_cnt   <= '0;
      calc_cnt   <= '0;
      unload_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (in_fire) load_cnt <= load_cnt + 3'd1;
      if (state == CALC) calc_cnt <= (calc_cnt == 4'd11) ? 4'd0 : calc_cnt + 4'd1;
      if (out_fire) unload_cnt <= unload_cnt + 3'd1;
    end
  end

  // NOTE: the register file is left out of reset; every frame overwrites all 8 entries before use.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_re[load_addr] <= bus.in_real;
      mem_im[load_addr] <= bus.in_imag;
    end else if (state == CALC) begin
      mem_re[addr_p] <= yp_re;
      mem_im[addr_p] <= yp_im;
      mem_re[addr_q] <= yq_re;
      mem_im[addr_q] <= yq_im;
    end
  end

endmodule

// File: tb/tb_ifft8_seq.sv
// Directed self-checking bench for ifft8_seq: impulse, flat, tone, backpressure,
// saturation and mid-frame reset, with hand-computed expected samples.
module tb_ifft8_seq;
  localparam int DW = 24;
  typedef logic signed [DW-1:0] frame_t [8];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifft8_seq_if #(.DW(DW)) bus ();
  ifft8_seq #(.DW(DW), .TW(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int last_in_cyc;

  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic frame_t fill(input int v);
    frame_t f;
    for (int i = 0; i < 8; i++) f[i] = DW'(v);
    return f;
  endfunction

  task automatic send_frame(input frame_t re, input frame_t im, output bit ok);
    int guard;
    ok = 1'b1;
    for (int n = 0; n < 8; n++) begin
      bus.in_valid = 1'b1;
      bus.in_real  = re[n];
      bus.in_imag  = im[n];
      guard = 0;
      while (bus.in_ready !== 1'b1 && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) ok = 1'b0;
      tick();
    end
    bus.in_valid = 1'b0;
    last_in_cyc  = cyc;
  endtask

  task automatic recv_frame(input int stall_at, output frame_t re, output frame_t im,
                            output bit ok, output int lat, output bit last_ok,
                            output bit stall_ok);
    int guard;
    ok = 1'b1; last_ok = 1'b1; stall_ok = 1'b1; lat = -1;
    re = fill(0); im = fill(0);
    bus.out_ready = 1'b1;
    for (int u = 0; u < 8; u++) begin
      guard = 0;
      while (bus.out_valid !== 1'b1 && guard < 60) begin
        tick();
        guard++;
      end
      if (guard >= 60) begin
        ok = 1'b0;
        return;
      end
      if (u == 0) lat = cyc - last_in_cyc;
      re[u] = bus.out_real;
      im[u] = bus.out_imag;
      if (bus.out_last !== (u == 7)) last_ok = 1'b0;
      if (u == stall_at) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          if (bus.out_valid !== 1'b1 || bus.out_real !== re[u] || bus.out_imag !== im[u] ||
              bus.in_ready !== 1'b0 || bus.busy !== 1'b1)
            stall_ok = 1'b0;
        end
        bus.out_ready = 1'b1;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] obs [6];
    logic [DW-1:0] exp [6];
    string         nm  [6];
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_real = '0; bus.in_imag = '0; bus.out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    obs[0] = DW'(bus.in_ready);  exp[0] = DW'(1); nm[0] = "in_ready";
    obs[1] = DW'(bus.out_valid); exp[1] = DW'(0); nm[1] = "out_valid";
    obs[2] = DW'(bus.out_last);  exp[2] = DW'(0); nm[2] = "out_last";
    obs[3] = DW'(bus.busy);      exp[3] = DW'(0); nm[3] = "busy";
    obs[4] = bus.out_real;       exp[4] = DW'(0); nm[4] = "out_real";
    obs[5] = bus.out_imag;       exp[5] = DW'(0); nm[5] = "out_imag";
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (obs[i] !== exp[i]) $display("FAIL reset %s: got %0d want %0d", nm[i], obs[i], exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_impulse();
    frame_t in_re, in_im, re, im;
    bit s_ok, r_ok, l_ok, st_ok;
    int lat;
    in_re = fill(0); in_im = fill(0);
    in_re[0] = DW'(8);
    send_frame(in_re, in_im, s_ok);
    recv_frame(-1, re, im, r_ok, lat, l_ok, st_ok);
    total_cnt++;
    if (!(s_ok && r_ok)) $display("FAIL impulse handshake: got timeout want 8 in / 8 out");
    else pass_cnt++;
    total_cnt++;
    if (lat !== 12) $display("FAIL impulse latency: got %0d want 12", lat);
    else pass_cnt++;
    total_cnt++;
    if (!l_ok) $display("FAIL impulse out_last: got misplaced want only on sample 7");
    else pass_cnt++;
    for (int u = 0; u < 8; u++) begin
      total_cnt++;
      if (re[u] !== DW'(1) || im[u] !== DW'(0))
        $display("FAIL impulse x%0d: got (%0d,%0d) want (1,0)", u, re[u], im[u]);
      else pass_cnt++;
    end
    total_cnt++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0)
      $display("FAIL impulse return_to_load: got in_ready=%b busy=%b out_valid=%b want 1 0 0",
               bus.in_ready, bus.busy, bus.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_flat();
    frame_t re, im;
    bit s_ok, r_ok, l_ok, st_ok;
    int lat;
    send_frame(fill(8), fill(0), s_ok);
    recv_frame(-1, re, im, r_ok, lat, l_ok, st_ok);
    total_cnt++;
    if (!(s_ok && r_ok && l_ok)) $display("FAIL flat framing: got ok=%b%b last=%b want 111", s_ok, r_ok, l_ok);
    else pass_cnt++;
    for (int u = 0; u < 8; u++) begin
      total_cnt++;
      if (re[u] !== DW'((u == 0) ? 8 : 0) || im[u] !== DW'(0))
        $display("FAIL flat x%0d: got (%0d,%0d) want (%0d,0)", u, re[u], im[u], (u == 0) ? 8 : 0);
      else pass_cnt++;
    end
  endtask

  task automatic run_tone(input string tag, input int stall_at);
    int     exp_re [8] = '{8192, 5792, 0, -5792, -8192, -5792, 0, 5792};
    int     exp_im [8] = '{0, 5792, 8192, 5792, 0, -5792, -8192, -5792};
    frame_t in_re, in_im, re, im;
    bit     s_ok, r_ok, l_ok, st_ok;
    int     lat, dr, di;
    in_re = fill(0); in_im = fill(0);
    in_re[1] = DW'(65536);
    send_frame(in_re, in_im, s_ok);
    recv_frame(stall_at, re, im, r_ok, lat, l_ok, st_ok);
    total_cnt++;
    if (!(s_ok && r_ok && l_ok)) $display("FAIL %s framing: got ok=%b%b last=%b want 111", tag, s_ok, r_ok, l_ok);
    else pass_cnt++;
    if (stall_at >= 0) begin
      total_cnt++;
      if (!st_ok) $display("FAIL %s stall_hold: got outputs changed want stable with in_ready=0", tag);
      else pass_cnt++;
    end
    for (int u = 0; u < 8; u++) begin
      dr = int'(re[u]) - exp_re[u];
      di = int'(im[u]) - exp_im[u];
      total_cnt++;
      if (dr > 1 || dr < -1 || di > 1 || di < -1)
        $display("FAIL %s x%0d: got (%0d,%0d) want (%0d,%0d) +-1", tag, u, re[u], im[u], exp_re[u], exp_im[u]);
      else pass_cnt++;
    end
  endtask

  task automatic test_tone();
    run_tone("tone", -1);
  endtask

  task automatic test_backpressure();
    run_tone("backpressure", 3);
  endtask

  task automatic test_saturation();
    frame_t re, im;
    bit s_ok, r_ok, l_ok, st_ok;
    int lat, dr, di, er;
    send_frame(fill(-8388608), fill(-8388608), s_ok);
    recv_frame(-1, re, im, r_ok, lat, l_ok, st_ok);
    total_cnt++;
    if (!(s_ok && r_ok)) $display("FAIL saturation framing: got timeout want 8 in / 8 out");
    else pass_cnt++;
    for (int u = 0; u < 8; u++) begin
      er = (u == 0) ? -8388608 : 0;
      dr = int'(re[u]) - er;
      di = int'(im[u]) - er;
      total_cnt++;
      if (dr > 1 || dr < -1 || di > 1 || di < -1)
        $display("FAIL saturation x%0d: got (%0d,%0d) want (%0d,%0d) +-1", u, re[u], im[u], er, er);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_calc();
    frame_t in_re, in_im, re, im;
    bit s_ok, r_ok, l_ok, st_ok, seen;
    int lat;
    in_re = fill(0); in_im = fill(0);
    in_re[1] = DW'(65536);
    send_frame(in_re, in_im, s_ok);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL midreset state: got in_ready=%b out_valid=%b busy=%b want 1 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    total_cnt++;
    if (seen) $display("FAIL midreset aborted_output: got out_valid=1 want 0 while idle");
    else pass_cnt++;
    send_frame(fill(8), fill(0), s_ok);
    recv_frame(-1, re, im, r_ok, lat, l_ok, st_ok);
    total_cnt++;
    if (!(s_ok && r_ok) || lat !== 12)
      $display("FAIL midreset new_frame: got ok=%b%b latency=%0d want 11 latency 12", s_ok, r_ok, lat);
    else pass_cnt++;
    for (int u = 0; u < 8; u++) begin
      total_cnt++;
      if (re[u] !== DW'((u == 0) ? 8 : 0) || im[u] !== DW'(0))
        $display("FAIL midreset x%0d: got (%0d,%0d) want (%0d,0)", u, re[u], im[u], (u == 0) ? 8 : 0);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_flat();
    test_tone();
    test_backpressure();
    test_saturation();
    test_reset_mid_calc();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
